// File: rtl/layer_seq.sv
// layer_seq: frame-level scheduler for the MNIST inference pipeline.
// Launches loader, conv1, pool1 and fc in order, tracks each stage's busy
// level for start/finish, runs a per-stage watchdog, flips the ping-pong
// feature-map bank once per frame and queues one pending frame request.
//
// Stage handshake (go/busy):
//   stage_go[i] is a level request. It is raised for the selected stage only
//   and held until that stage answers by raising stage_busy[i] (the ack).
//   go then drops on the first WAIT_DONE cycle. The stage is finished when it
//   lowers stage_busy[i]. busy of any non-selected stage is ignored, and a
//   busy that is already high when go is raised counts as the ack.
//
// state_dbg encoding: 0 IDLE, 1 LAUNCH, 2 WAIT_ACK, 3 WAIT_DONE, 4 NEXT,
// 5 DONE, 6 ERR.
module layer_seq #(
  parameter int NUM_STAGES  = 4,    // stage index is 2 bits, so at most 4
  parameter int ACK_TIMEOUT = 16,   // cycles allowed from go to busy
  parameter int RUN_TIMEOUT = 4096, // cycles a stage may hold busy
  parameter int CNT_W       = 13    // watchdog width, must hold RUN_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_busy,
  output logic [NUM_STAGES-1:0] stage_go,
  output logic                  bank_sel,
  output logic                  seq_busy,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt,
  output logic                  err,
  output logic [1:0]            err_stage,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_NEXT      = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  // Last watchdog values before a timeout fires, and the last stage index.
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_STAGES - 1);

  state_t                  state;
  logic                    pending;
  logic [1:0]              idx;
  logic [CNT_W-1:0]        wdog;
  logic                    sel_busy;
  logic [NUM_STAGES-1:0]   go_onehot;

  // Busy level of the currently selected stage and its one-hot go pattern.
  assign sel_busy  = stage_busy[idx];
  assign go_onehot = NUM_STAGES'(1) << idx;
  assign state_dbg = state;

  // Sequencer FSM: state, index, watchdog, pending flag and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      stage_go   <= '0;
      bank_sel   <= 1'b0;
      seq_busy   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      err        <= 1'b0;
      err_stage  <= 2'd0;
      pending    <= 1'b0;
      idx        <= 2'd0;
      wdog       <= '0;
    end else if (abort) begin
      // Abort drops the frame in flight and any queued request, but keeps
      // the frame count and bank so downstream buffers stay consistent.
      state      <= S_IDLE;
      stage_go   <= '0;
      seq_busy   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_stage  <= 2'd0;
      pending    <= 1'b0;
      idx        <= 2'd0;
      wdog       <= '0;
    end else begin
      frame_done <= 1'b0;

      // A request arriving mid-frame is queued; a second one is lost since
      // the flag is already set. DONE consumes requests directly instead.
      if (frame_start && seq_busy && (state != S_DONE)) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            idx      <= 2'd0;
            seq_busy <= 1'b1;
            state    <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          stage_go <= go_onehot;
          wdog     <= '0;
          state    <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          // The ack beats the timeout when both land on the same cycle.
          if (sel_busy) begin
            stage_go <= '0;
            wdog     <= '0;
            state    <= S_WAIT_DONE;
          end else if (wdog == ACK_LAST) begin
            stage_go  <= '0;
            err       <= 1'b1;
            err_stage <= idx;
            seq_busy  <= 1'b0;
            state     <= S_ERR;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        S_WAIT_DONE: begin
          stage_go <= '0;
          // Completion beats the timeout when both land on the same cycle.
          if (!sel_busy) begin
            state <= S_NEXT;
          end else if (wdog == RUN_LAST) begin
            err       <= 1'b1;
            err_stage <= idx;
            seq_busy  <= 1'b0;
            state     <= S_ERR;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        S_NEXT: begin
          if (idx == IDX_LAST) begin
            // Frame complete: pulse done, count it and swap buffer banks.
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            bank_sel   <= ~bank_sel;
            state      <= S_DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= S_LAUNCH;
          end
        end

        S_DONE: begin
          // Chain straight into the next frame when one is waiting.
          if (pending || frame_start) begin
            pending <= 1'b0;
            idx     <= 2'd0;
            state   <= S_LAUNCH;
          end else begin
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_ERR: begin
          // Sticky until abort or reset; new requests are ignored here.
          stage_go  <= '0;
          err       <= 1'b1;
          err_stage <= idx;
          seq_busy  <= 1'b0;
        end

        default: begin
          stage_go <= '0;
          seq_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: directed scenarios with randomized stage timing for
// layer_seq. Expected go/done/err event times come from a timeline model
// built from the stage ack delay and busy duration of each stage.
module tb_layer_seq;

  localparam int NS          = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int RUN_TIMEOUT = 4096;
  localparam int W           = 32;

  localparam logic [3:0] EV_GO   = 4'd1;
  localparam logic [3:0] EV_DONE = 4'd2;
  localparam logic [3:0] EV_ERR  = 4'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_busy = '0;
  logic [NS-1:0] stage_go;
  logic          bank_sel;
  logic          seq_busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          err;
  logic [1:0]    err_stage;
  logic [2:0]    state_dbg;

  layer_seq #(
    .NUM_STAGES (NS),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .RUN_TIMEOUT(RUN_TIMEOUT),
    .CNT_W      (13)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .abort      (abort),
    .stage_busy (stage_busy),
    .stage_go   (stage_go),
    .bank_sel   (bank_sel),
    .seq_busy   (seq_busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err        (err),
    .err_stage  (err_stage),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int          ack_dly[NS];
  int          hold[NS];
  int          t_go[NS];
  int          exp_go[NS];
  int          cur_stage = -1;
  int          overlap_cnt = 0;
  logic [NS-1:0] prev_go = '0;
  logic        prev_err = 1'b0;
  int          exp_cnt = 0;
  logic        exp_bank = 1'b0;

  function automatic logic [W-1:0] ev(input logic [3:0] k, input int s, input int t);
    return {k, s[1:0], t[25:0]};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: observe DUT outputs, then drive the stage models for the
  // new cycle. Single-cycle requests are cleared after each edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < NS; s++) begin
      if (stage_go[s] && !prev_go[s]) begin
        obs_q.push_back(ev(EV_GO, s, cyc));
        t_go[s]   = cyc;
        cur_stage = s;
      end
    end
    if ($countones(stage_go) > 1) overlap_cnt++;
    if (frame_done) begin
      obs_q.push_back(ev(EV_DONE, 0, cyc));
      cur_stage = -1;
    end
    if (err && !prev_err) obs_q.push_back(ev(EV_ERR, int'(err_stage), cyc));
    prev_go  = stage_go;
    prev_err = err;
    // Stage models: busy for hold cycles starting ack_dly after go; stages
    // already finished in this frame toggle busy randomly as noise.
    for (int s = 0; s < NS; s++) begin
      if (t_go[s] >= 0 && cyc >= t_go[s] + ack_dly[s] &&
          cyc < t_go[s] + ack_dly[s] + hold[s])
        stage_busy[s] = 1'b1;
      else if (s < cur_stage)
        stage_busy[s] = 1'($urandom_range(0, 1));
      else
        stage_busy[s] = 1'b0;
    end
    frame_start = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_resp();
    for (int s = 0; s < NS; s++) t_go[s] = -1;
    stage_busy = '0;
    cur_stage  = -1;
  endtask

  task automatic rand_profile(input int dmax, input int hmax);
    for (int s = 0; s < NS; s++) begin
      ack_dly[s] = $urandom_range(0, dmax);
      hold[s]    = $urandom_range(1, hmax);
    end
  endtask

  // Timeline model: request seen in cycle c puts go[0] at c+2. A stage with
  // go at g acks at g+D and finishes at g+D+H; the next go follows 3 cycles
  // after busy falls, and DONE 2 cycles after the last stage's busy falls.
  task automatic model_frame(input int c, output int t_end, output bit is_err);
    int g;
    g      = c + 2;
    t_end  = 0;
    is_err = 1'b0;
    for (int s = 0; s < NS; s++) begin
      exp_go[s] = g;
      exp_q.push_back(ev(EV_GO, s, g));
      if (ack_dly[s] >= ACK_TIMEOUT) begin
        t_end  = g + ACK_TIMEOUT;
        is_err = 1'b1;
        exp_q.push_back(ev(EV_ERR, s, t_end));
        return;
      end
      if (hold[s] > RUN_TIMEOUT) begin
        t_end  = g + ack_dly[s] + 1 + RUN_TIMEOUT;
        is_err = 1'b1;
        exp_q.push_back(ev(EV_ERR, s, t_end));
        return;
      end
      if (s == NS - 1) t_end = g + ack_dly[s] + hold[s] + 2;
      else             g     = g + ack_dly[s] + hold[s] + 3;
    end
    exp_q.push_back(ev(EV_DONE, 0, t_end));
    exp_cnt  = (exp_cnt + 1) % 256;
    exp_bank = ~exp_bank;
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_ev"}, obs_q[i], exp_q[i]);
    chk({tag, "_overlap"}, overlap_cnt, 0);
    obs_q.delete();
    exp_q.delete();
    overlap_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_go"},        stage_go,   0);
    chk({tag, "_bank"},      bank_sel,   0);
    chk({tag, "_seq_busy"},  seq_busy,   0);
    chk({tag, "_done"},      frame_done, 0);
    chk({tag, "_cnt"},       frame_cnt,  0);
    chk({tag, "_err"},       err,        0);
    chk({tag, "_err_stage"}, err_stage,  0);
    chk({tag, "_state"},     state_dbg,  ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c, te, d1, d2, g2, g3;
    bit e;

    clear_resp();
    for (int s = 0; s < NS; s++) begin
      ack_dly[s] = 0;
      hold[s]    = 1;
    end

    // Reset state
    rst = 1'b1;
    step_n(3);
    check_reset("reset");
    rst = 1'b0;
    step();

    // Nominal frame: ack after 3 cycles, busy for 10
    for (int s = 0; s < NS; s++) begin
      ack_dly[s] = 3;
      hold[s]    = 10;
    end
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, te, e);
    step_to(te);
    chk("nom_done_pulse", frame_done, 1);
    chk("nom_busy_in_done", seq_busy, 1);
    chk("nom_cnt", frame_cnt, exp_cnt);
    chk("nom_bank", bank_sel, exp_bank);
    step();
    chk("nom_busy_fall", seq_busy, 0);
    chk("nom_done_once", frame_done, 0);
    chk("nom_idle", state_dbg, ST_IDLE);
    step_n(5);
    check_events("nom");

    // Back-to-back: request during stage 2 queued, one during stage 3 dropped
    rand_profile(6, 20);
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, d1, e);
    g2 = exp_go[2];
    g3 = exp_go[3];
    step_to(g2);
    frame_start = 1'b1;
    step_to(g3);
    frame_start = 1'b1;
    step_to(d1);
    chk("b2b_done1", frame_done, 1);
    model_frame(d1, d2, e);
    step();
    chk("b2b_relaunch", state_dbg, ST_LAUNCH);
    chk("b2b_busy_kept", seq_busy, 1);
    step_to(d2);
    chk("b2b_done2", frame_done, 1);
    step();
    chk("b2b_idle", seq_busy, 0);
    step_n(20);
    check_events("b2b");
    chk("b2b_cnt", frame_cnt, exp_cnt);
    chk("b2b_bank", bank_sel, exp_bank);

    // Ack timeout on stage 1; later request ignored; abort clears error
    for (int s = 0; s < NS; s++) begin
      ack_dly[s] = 2;
      hold[s]    = 5;
    end
    ack_dly[1] = 1000;
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, te, e);
    step_to(te - 1);
    chk("ackto_pre_err", err, 0);
    step();
    chk("ackto_err", err, 1);
    chk("ackto_err_stage", err_stage, 1);
    chk("ackto_go", stage_go, 0);
    chk("ackto_state", state_dbg, ST_ERR);
    frame_start = 1'b1;
    step_n(8);
    chk("ackto_ignore_req", state_dbg, ST_ERR);
    chk("ackto_sticky", err, 1);
    chk("ackto_cnt", frame_cnt, exp_cnt);
    check_events("ackto");
    abort = 1'b1;
    step();
    clear_resp();
    chk("ackto_abort_err", err, 0);
    chk("ackto_abort_stage", err_stage, 0);
    chk("ackto_abort_state", state_dbg, ST_IDLE);
    chk("ackto_abort_cnt", frame_cnt, exp_cnt);
    chk("ackto_abort_bank", bank_sel, exp_bank);

    // Run timeout on stage 1; abort with a simultaneous request (lost)
    for (int s = 0; s < NS; s++) begin
      ack_dly[s] = 2;
      hold[s]    = 4;
    end
    hold[1] = 5000;
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, te, e);
    step_to(te);
    chk("runto_err", err, 1);
    chk("runto_err_stage", err_stage, 1);
    abort       = 1'b1;
    frame_start = 1'b1;
    step();
    clear_resp();
    chk("runto_abort_state", state_dbg, ST_IDLE);
    chk("runto_abort_err", err, 0);
    chk("runto_abort_cnt", frame_cnt, exp_cnt);
    step_n(6);
    chk("runto_req_lost", seq_busy, 0);
    check_events("runto");
    rand_profile(6, 20);
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, te, e);
    step_to(te + 1);
    step_n(4);
    check_events("post_abort");
    chk("post_abort_cnt", frame_cnt, exp_cnt);
    chk("post_abort_bank", bank_sel, exp_bank);

    // Boundaries: busy pre-high, ack on last watchdog cycle, full run budget
    rand_profile(4, 10);
    ack_dly[0] = 0;
    hold[1]    = RUN_TIMEOUT;
    ack_dly[2] = ACK_TIMEOUT - 1;
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, te, e);
    step_to(te + 1);
    step_n(4);
    chk("bound_no_err", err, 0);
    check_events("bound");
    chk("bound_cnt", frame_cnt, exp_cnt);

    // Reset during WAIT_DONE of stage 2
    rand_profile(4, 10);
    hold[2] = 10;
    c = cyc;
    frame_start = 1'b1;
    model_frame(c, te, e);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    step_to(exp_go[2] + ack_dly[2] + 3);
    rst = 1'b1;
    step();
    clear_resp();
    check_reset("midrst");
    rst      = 1'b0;
    exp_cnt  = 0;
    exp_bank = 1'b0;
    step_n(8);
    check_events("midrst");

    // 256 frames wrap the frame counter back to 0
    for (int f = 0; f < 256; f++) begin
      rand_profile(2, 3);
      c = cyc;
      frame_start = 1'b1;
      model_frame(c, te, e);
      step_to(te);
      if (f == 254) chk("wrap_255", frame_cnt, exp_cnt);
      step();
    end
    step_n(4);
    check_events("wrap");
    chk("wrap_zero", frame_cnt, 8'd0);
    chk("wrap_bank", bank_sel, exp_bank);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
